// File: rtl/cook_sequencer.sv
// cook_sequencer
//   Sequences the magnetron for one cook cycle. A cook time is keyed in as
//   four BCD digits (MM:SS) and counted down on a 1 Hz tick. The block also
//   handles the start/stop/clear/door interlock and the end-of-cook beep.
//
//   Ports
//     clk          system clock, rising edge
//     rstn         asynchronous active-low reset
//     tick_1hz     single-cycle 1 Hz timebase pulse
//     key_valid    single-cycle pulse qualifying key_digit
//     key_digit    BCD keypad digit (10-15 ignored)
//     start_p      start request pulse
//     stop_p       stop request pulse
//     clear_p      clear request pulse
//     door_closed  1 = door closed (level)
//     mag_on       magnetron enable, high exactly while state==COOK
//     min_tens     display digit, minutes tens
//     min_ones     display digit, minutes ones
//     sec_tens     display digit, seconds tens
//     sec_ones     display digit, seconds ones
//     state        IDLE=0 ENTRY=1 COOK=2 PAUSE=3 DONE=4
//     done_beep    end-of-cook alarm, held for BEEP_TICKS ticks
module cook_sequencer #(
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       clear_p,
    input  logic       door_closed,
    output logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       done_beep
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_TICKS - 1);

    state_t          cur_state, nxt_state;
    logic [3:0]      mt_q, mo_q, st_q, so_q;
    logic [3:0]      mt_d, mo_d, st_d, so_d;
    logic [3:0]      dec_mt, dec_mo, dec_st, dec_so;
    logic            beep_q, beep_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            time_zero, dec_zero, key_ok;

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                       (st_q == 4'd0) && (so_q == 4'd0);
    assign dec_zero  = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                       (dec_st == 4'd0) && (dec_so == 4'd0);

    // One-second BCD decrement; borrowing into seconds always reloads 59,
    // so an entered 00:90 counts down 90 s before reaching minute borrows.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else if (st_q != 4'd0) begin
            dec_st = st_q - 4'd1;
            dec_so = 4'd9;
        end else if (mo_q != 4'd0) begin
            dec_mo = mo_q - 4'd1;
            dec_st = 4'd5;
            dec_so = 4'd9;
        end else if (mt_q != 4'd0) begin
            dec_mt = mt_q - 4'd1;
            dec_mo = 4'd9;
            dec_st = 4'd5;
            dec_so = 4'd9;
        end
    end

    // Next-state logic. Each branch chain follows the event priority
    // clear > stop > door open > start > key > tick, so only one event acts.
    always_comb begin
        nxt_state = cur_state;
        mt_d      = mt_q;
        mo_d      = mo_q;
        st_d      = st_q;
        so_d      = so_q;
        beep_d    = beep_q;
        cnt_d     = cnt_q;

        if (clear_p) begin
            nxt_state = IDLE;
            {mt_d, mo_d, st_d, so_d} = '0;
            beep_d    = 1'b0;
            cnt_d     = '0;
        end else begin
            case (cur_state)
                IDLE, ENTRY: begin
                    if (stop_p) begin
                        nxt_state = IDLE;
                        {mt_d, mo_d, st_d, so_d} = '0;
                    end else if (start_p && door_closed && !time_zero) begin
                        nxt_state = COOK;
                    end else if (key_ok) begin
                        mt_d      = mo_q;
                        mo_d      = st_q;
                        st_d      = so_q;
                        so_d      = key_digit;
                        nxt_state = ENTRY;
                    end
                end
                COOK: begin
                    if (stop_p || !door_closed) begin
                        nxt_state = PAUSE;
                    end else if (tick_1hz) begin
                        if (time_zero || dec_zero) begin
                            nxt_state = DONE;
                            beep_d    = 1'b1;
                            cnt_d     = '0;
                        end
                        mt_d = dec_mt;
                        mo_d = dec_mo;
                        st_d = dec_st;
                        so_d = dec_so;
                    end
                end
                PAUSE: begin
                    if (stop_p) begin
                        nxt_state = IDLE;
                        {mt_d, mo_d, st_d, so_d} = '0;
                    end else if (start_p && door_closed) begin
                        nxt_state = COOK;
                    end
                end
                DONE: begin
                    if (stop_p || !door_closed) begin
                        nxt_state = IDLE;
                        beep_d    = 1'b0;
                        cnt_d     = '0;
                    end else if (tick_1hz) begin
                        if (cnt_q == BEEP_LAST) begin
                            nxt_state = IDLE;
                            beep_d    = 1'b0;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    {mt_d, mo_d, st_d, so_d} = '0;
                    beep_d    = 1'b0;
                    cnt_d     = '0;
                end
            endcase
        end
    end

    // mag_on is registered from the next state so it changes on the same
    // edge as state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state <= IDLE;
            mt_q      <= '0;
            mo_q      <= '0;
            st_q      <= '0;
            so_q      <= '0;
            beep_q    <= 1'b0;
            cnt_q     <= '0;
            mag_on    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            beep_q    <= beep_d;
            cnt_q     <= cnt_d;
            mag_on    <= (nxt_state == COOK);
        end
    end

    assign min_tens  = mt_q;
    assign min_ones  = mo_q;
    assign sec_tens  = st_q;
    assign sec_ones  = so_q;
    assign state     = cur_state;
    assign done_beep = beep_q;

endmodule
